// File: rtl/crc8_frame_rx_if.sv
// Bit-serial link bundle between the PHY/bit-sync side (master) and the CRC-8 frame receiver (slave).
// CRC8_FRAME_RX_STATS_EN adds the good/bad frame counters.
interface crc8_frame_rx_if;
   logic       sof;
   logic       bitval;
   logic       bitstrb;
   logic [7:0] data;
   logic       data_valid;
   logic [7:0] len;
   logic       frame_done;
   logic       crc_ok;
   logic       len_err;
   logic       to_err;
   logic       busy;
`ifdef CRC8_FRAME_RX_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;
`endif

   modport master (
      output sof, bitval, bitstrb,
      input  data, data_valid, len, frame_done, crc_ok, len_err, to_err, busy
`ifdef CRC8_FRAME_RX_STATS_EN
      , good_cnt, bad_cnt
`endif
   );

   modport slave (
      input  sof, bitval, bitstrb,
      output data, data_valid, len, frame_done, crc_ok, len_err, to_err, busy
`ifdef CRC8_FRAME_RX_STATS_EN
      , good_cnt, bad_cnt
`endif
   );
endinterface

// File: rtl/crc8_frame_rx.sv
// Serial CRC-8 (poly 0xD5, init 0, MSB-first) frame receiver: [LEN][payload][CRC].
// Optional good/bad frame counters are enabled by CRC8_FRAME_RX_STATS_EN.
module crc8_frame_rx #(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic          clk,
   input logic          clear,
   crc8_frame_rx_if.slave bus
);

   localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
   localparam logic [15:0] ToLast  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLen, StData, StCrc} state_e;

   state_e      state_q;
   logic [7:0]  crc_q;
   logic [6:0]  sr_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  byte_cnt_q;
   logic [15:0] to_cnt_q;
   logic [7:0]  data_q;
   logic [7:0]  len_q;
   logic        data_valid_q;
   logic        frame_done_q;
   logic        crc_ok_q;
   logic        len_err_q;
   logic        to_err_q;

   logic [7:0] byte_nxt;
   logic [7:0] crc_nxt;

   always_comb begin
      byte_nxt = {sr_q, bus.bitval};
      crc_nxt  = {crc_q[6:0], 1'b0} ^ ((bus.bitval ^ crc_q[7]) ? 8'hD5 : 8'h00);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= StIdle;
         crc_q        <= 8'h00;
         sr_q         <= 7'h00;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 8'h00;
         to_cnt_q     <= 16'h0000;
         data_q       <= 8'h00;
         len_q        <= 8'h00;
         data_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         len_err_q    <= 1'b0;
         to_err_q     <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         if (bus.sof) begin
            // A frame in progress is dropped without reporting.
            state_q    <= StLen;
            crc_q      <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'h00;
            to_cnt_q   <= 16'h0000;
            crc_ok_q   <= 1'b0;
            len_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
         end else if (state_q != StIdle) begin
            if (bus.bitstrb) begin
               to_cnt_q  <= 16'h0000;
               crc_q     <= crc_nxt;
               sr_q      <= byte_nxt[6:0];
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  unique case (state_q)
                     StLen: begin
                        len_q <= byte_nxt;
                        if (byte_nxt == 8'h00) begin
                           state_q <= StCrc;
                        end else if (byte_nxt > MaxLenB) begin
                           state_q      <= StIdle;
                           frame_done_q <= 1'b1;
                           len_err_q    <= 1'b1;
                           crc_ok_q     <= 1'b0;
                        end else begin
                           state_q <= StData;
                        end
                     end
                     StData: begin
                        data_q       <= byte_nxt;
                        data_valid_q <= 1'b1;
                        byte_cnt_q   <= byte_cnt_q + 8'd1;
                        if (byte_cnt_q + 8'd1 == len_q) state_q <= StCrc;
                     end
                     StCrc: begin
                        state_q      <= StIdle;
                        frame_done_q <= 1'b1;
                        crc_ok_q     <= (crc_nxt == 8'h00);
                     end
                     default: state_q <= StIdle;
                  endcase
               end
            end else if (to_cnt_q == ToLast) begin
               // Counter would reach TIMEOUT on this idle cycle.
               state_q      <= StIdle;
               to_cnt_q     <= 16'h0000;
               frame_done_q <= 1'b1;
               to_err_q     <= 1'b1;
               crc_ok_q     <= 1'b0;
            end else begin
               to_cnt_q <= to_cnt_q + 16'd1;
            end
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.len        = len_q;
   assign bus.frame_done = frame_done_q;
   assign bus.crc_ok     = crc_ok_q;
   assign bus.len_err    = len_err_q;
   assign bus.to_err     = to_err_q;
   assign bus.busy       = (state_q != StIdle);

`ifdef CRC8_FRAME_RX_STATS_EN
   logic [15:0] good_cnt_q;
   logic [15:0] bad_cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         good_cnt_q <= 16'h0000;
         bad_cnt_q  <= 16'h0000;
      end else if (frame_done_q) begin
         if (crc_ok_q) begin
            if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
         end else begin
            if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
         end
      end
   end

   assign bus.good_cnt = good_cnt_q;
   assign bus.bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: doc/crc8_frame_rx.md
Name: crc8_frame_rx

Overview:
- Serial frame receiver and checker for the bit-serial CRC-8 link. It is the receive end of the link whose transmit side generates the CRC with polynomial 0xD5 (x^8+x^7+x^6+x^4+x^2+1), init 0x00, MSB-first, no final XOR.
- Accepts one bit per strobe and deserializes the frame [LEN byte][LEN payload bytes][CRC byte].
- Emits the payload bytes, then reports pass/fail plus length and timeout errors.
- Sits between the serial PHY/bit-sync logic and the byte-level command parser.

Parameters:
- MAX_LEN, 16: largest legal payload length in bytes; 1..255.
- TIMEOUT, 1024: CLK cycles allowed between consecutive BITSTRB pulses inside a frame; 2..65535.

Ports:
- CLK  input  1  system clock.
- CLEAR  input  1  synchronous, active-high reset.
- SOF  input  1  one-cycle start-of-frame pulse; (re)starts reception.
- BITVAL  input  1  serial data bit, valid when BITSTRB=1.
- BITSTRB  input  1  one-cycle bit-valid strobe, synchronous to CLK (clock enable, not a clock).
- DATA  output  8  last completed payload byte.
- DATA_VALID  output  1  one-cycle pulse: DATA holds a new payload byte.
- LEN  output  8  length byte of the current/last frame.
- FRAME_DONE  output  1  one-cycle pulse: frame finished or aborted; status outputs valid.
- CRC_OK  output  1  last frame's CRC remainder was zero.
- LEN_ERR  output  1  last frame aborted: LEN > MAX_LEN.
- TO_ERR  output  1  last frame aborted on bit timeout.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (CLEAR=1 at a CLK edge): state=IDLE, CRC reg=0x00, DATA=0x00, LEN=0x00, all pulses/flags 0, counters 0. CLEAR overrides all other inputs, mid-frame included.
- CRC update per accepted bit:
  - inv = BITVAL ^ crc[7].
  - crc = {crc[6:0],1'b0} ^ (inv ? 8'hD5 : 8'h00).
  - Applied to every bit of LEN, payload and CRC byte. Remainder 0x00 after the CRC byte means pass.
- States: IDLE, LEN, DATA, CRC. Bits are shifted MSB-first into an 8-bit shift register; a 3-bit bit counter marks byte boundaries.
- IDLE: BITSTRB is ignored. SOF moves to LEN and clears crc, bit counter, byte counter and timeout counter.
- LEN: on the 8th bit, LEN is latched.
  - Byte=0: go to CRC.
  - Byte>MAX_LEN: abort. FRAME_DONE=1, LEN_ERR=1, CRC_OK=0, go to IDLE; remaining bits are ignored until the next SOF.
  - Otherwise: go to DATA.
- DATA: on each 8th bit, DATA is loaded and DATA_VALID pulses on the next cycle (1-cycle latency after the strobe). The byte counter increments; when it reaches LEN, go to CRC.
- CRC: on the 8th bit, go to IDLE. On the next cycle FRAME_DONE=1 and CRC_OK=(updated crc==0). The CRC byte is not output on DATA.
- Status flags CRC_OK, LEN_ERR and TO_ERR hold until the next SOF or CLEAR. All are cleared by SOF.
- Timeout: in LEN/DATA/CRC the timeout counter increments each cycle without BITSTRB and clears on BITSTRB. On reaching TIMEOUT: FRAME_DONE=1, TO_ERR=1, CRC_OK=0, go to IDLE. No DATA_VALID for a partial byte.
- SOF while BUSY: the current frame is silently dropped, with no FRAME_DONE, and a new frame starts.
- SOF and BITSTRB in the same cycle: SOF wins and the bit is discarded.
- At most one of LEN_ERR and TO_ERR is set per frame. DATA_VALID and FRAME_DONE never assert in the same cycle.

Optional Feature:
- Macro: CRC8_FRAME_RX_STATS_EN.
- Defined:
  - Extra outputs GOOD_CNT[15:0] and BAD_CNT[15:0].
  - GOOD_CNT increments on FRAME_DONE with CRC_OK=1. BAD_CNT increments on every other FRAME_DONE.
  - Both saturate at 0xFFFF and clear on CLEAR.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Frame bits 0x00 (LEN), 0x00 (CRC) -> no DATA_VALID; FRAME_DONE one cycle after last strobe; CRC_OK=1, LEN=0.
- Frame 0x01, 0x00, 0x0B with 3-cycle strobe spacing -> DATA_VALID once with DATA=0x00; FRAME_DONE with CRC_OK=1.
- Same frame with CRC byte 0x0A -> DATA=0x00 emitted; FRAME_DONE, CRC_OK=0, LEN_ERR=0, TO_ERR=0.
- LEN=0x11 with MAX_LEN=16 -> FRAME_DONE after 8th bit, LEN_ERR=1; following strobes ignored, BUSY=0.
- Stop strobes after 12 bits (TIMEOUT=8) -> FRAME_DONE exactly 8 idle cycles after last strobe, TO_ERR=1; no DATA_VALID. Separately: SOF mid-frame, then a valid frame -> one FRAME_DONE only, CRC_OK=1.
- CLEAR asserted mid-payload -> next cycle all outputs at reset values, state IDLE. With CRC8_FRAME_RX_STATS_EN: two good frames and one bad frame -> GOOD_CNT=2, BAD_CNT=1.
